cpu_thread_sched: RTL and testbench

// Round-robin thread scheduler for the sha512unit CPU. Tracks a per-thread ready bit, picks the next ready

---
 rtl/cpu_thread_sched_pkg.sv | 14 +
 rtl/cpu_thread_sched_rr_pick.sv | 23 ++
 rtl/cpu_thread_sched.sv | 79 +++++++
 tb/tb_cpu_thread_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_thread_sched_pkg.sv
// cpu_thread_sched_pkg: shared sizes and scheduler state encodings
package cpu_thread_sched_pkg;
    localparam int N_THREADS = 16;
    localparam int N_THREADS_MSB = $clog2(N_THREADS) - 1;

    typedef enum logic [2:0] {
        TS_IDLE     = 3'd0,
        TS_PICK     = 3'd1,
        TS_PREFETCH = 3'd2,
        TS_LOAD     = 3'd3,
        TS_RUN      = 3'd4,
        TS_SAVE     = 3'd5
    } ts_state_t;
endpackage

// File: rtl/cpu_thread_sched_rr_pick.sv
// cpu_thread_sched_rr_pick: combinational rotate-priority encoder (first set bit at or after start, wrapping)
module cpu_thread_sched_rr_pick #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] index
);
    logic [N-1:0] rot;
    logic [W-1:0] off;

    // rotate so start lands at bit 0, take the lowest set bit, rotate the offset back
    always_comb begin
        rot = '0;
        off = '0;
        for (int i = 0; i < N; i++) rot[i] = mask[start + W'(i)];
        for (int i = N - 1; i >= 0; i--) if (rot[i]) off = W'(i);
        found = |mask;
        index = start + off;
    end
endmodule

// File: rtl/cpu_thread_sched.sv
// cpu_thread_sched: round-robin thread scheduler sequencing save/prefetch/load of per-thread flags
module cpu_thread_sched
    import cpu_thread_sched_pkg::*;
(
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     ready_set_en,
    input  logic [N_THREADS_MSB:0]   ready_set_num,
    input  logic                     switch_req,
    input  logic                     switch_keep,
    output logic [N_THREADS_MSB:0]   thread_num,
    output logic                     load_en,
    output logic                     save_en,
    output logic                     cpu_en,
    output logic [N_THREADS-1:0]     ready_mask
);
    ts_state_t              state;
    logic [N_THREADS-1:0]   set_bits;
    logic [N_THREADS-1:0]   clr_bits;
    logic                   found;
    logic [N_THREADS_MSB:0] winner;

    // set wins over a simultaneous clear of the same thread
    always_comb begin
        set_bits = ready_set_en ? (N_THREADS'(1) << ready_set_num) : '0;
        clr_bits = (state == TS_RUN && switch_req && !switch_keep) ? (N_THREADS'(1) << thread_num) : '0;
    end

    cpu_thread_sched_rr_pick #(.N(N_THREADS), .W(N_THREADS_MSB + 1)) u_pick (
        .mask  (ready_mask),
        .start (thread_num + 1'b1),
        .found (found),
        .index (winner)
    );

    // scheduler FSM with registered outputs and ready-bit register
    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= TS_IDLE;
            thread_num <= '1;
            load_en    <= 1'b0;
            save_en    <= 1'b0;
            cpu_en     <= 1'b0;
            ready_mask <= '0;
        end else begin
            load_en    <= 1'b0;
            save_en    <= 1'b0;
            ready_mask <= (ready_mask & ~clr_bits) | set_bits;
            case (state)
                TS_IDLE: if (|ready_mask) state <= TS_PICK;
                TS_PICK: begin
                    if (found) begin
                        thread_num <= winner;
                        state      <= TS_PREFETCH;
                    end else begin
                        state <= TS_IDLE;
                    end
                end
                TS_PREFETCH: begin
                    load_en <= 1'b1;
                    state   <= TS_LOAD;
                end
                TS_LOAD: begin
                    cpu_en <= 1'b1;
                    state  <= TS_RUN;
                end
                TS_RUN: begin
                    if (switch_req) begin
                        cpu_en  <= 1'b0;
                        save_en <= 1'b1;
                        state   <= TS_SAVE;
                    end
                end
                TS_SAVE: state <= TS_PICK;
                default: state <= TS_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_thread_sched.sv
// tb_cpu_thread_sched: directed self-checking bench for cpu_thread_sched
module tb_cpu_thread_sched;
    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        ready_set_en = 1'b0;
    logic [3:0]  ready_set_num = '0;
    logic        switch_req = 1'b0;
    logic        switch_keep = 1'b0;
    logic [3:0]  thread_num;
    logic        load_en;
    logic        save_en;
    logic        cpu_en;
    logic [15:0] ready_mask;

    int vec = 0;
    int errs = 0;

    cpu_thread_sched dut (
        .CLK           (CLK),
        .reset         (reset),
        .ready_set_en  (ready_set_en),
        .ready_set_num (ready_set_num),
        .switch_req    (switch_req),
        .switch_keep   (switch_keep),
        .thread_num    (thread_num),
        .load_en       (load_en),
        .save_en       (save_en),
        .cpu_en        (cpu_en),
        .ready_mask    (ready_mask)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        ready_set_en = 1'b0;
        switch_req = 1'b0;
        switch_keep = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_set(input logic [3:0] n);
        ready_set_en = 1'b1;
        ready_set_num = n;
        tick();
        ready_set_en = 1'b0;
    endtask

    // advance until load_en is seen (bounded); leaves the bench sampling the LOAD cycle
    task automatic wait_load(output bit ok, output bit saw_save);
        ok = 1'b0;
        saw_save = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (save_en) saw_save = 1'b1;
            if (load_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // one switch_req pulse in RUN, then follow the switch until cpu_en returns (bounded)
    task automatic do_switch(input bit keep, input bit set_en, input logic [3:0] set_num,
                             output bit sv_seen, output logic [3:0] sv, output logic [3:0] ld,
                             output int gap, output bit ok);
        switch_req = 1'b1;
        switch_keep = keep;
        ready_set_en = set_en;
        ready_set_num = set_num;
        tick();
        switch_req = 1'b0;
        ready_set_en = 1'b0;
        sv_seen = save_en;
        sv = thread_num;
        ld = 4'h0;
        gap = 0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (cpu_en) begin
                ok = 1'b1;
                break;
            end
            gap++;
            if (load_en) ld = thread_num;
            tick();
        end
    endtask

    task automatic test_reset;
        do_reset();
        vec++; if (thread_num !== 4'd15) begin errs++; $display("FAIL reset_thread_num got %0d want 15", thread_num); end
        vec++; if (load_en !== 1'b0) begin errs++; $display("FAIL reset_load_en got %b want 0", load_en); end
        vec++; if (save_en !== 1'b0) begin errs++; $display("FAIL reset_save_en got %b want 0", save_en); end
        vec++; if (cpu_en !== 1'b0) begin errs++; $display("FAIL reset_cpu_en got %b want 0", cpu_en); end
        vec++; if (ready_mask !== 16'h0) begin errs++; $display("FAIL reset_ready_mask got %h want 0000", ready_mask); end
    endtask

    task automatic test_first_load;
        bit saw_save = 1'b0;
        do_reset();
        pulse_set(4'd3);
        vec++; if (ready_mask !== 16'h0008) begin errs++; $display("FAIL first_mask got %h want 0008", ready_mask); end
        tick();
        saw_save |= save_en;
        tick();
        saw_save |= save_en;
        vec++; if (thread_num !== 4'd3 || load_en !== 1'b0) begin errs++; $display("FAIL first_prefetch got num=%0d load=%b want num=3 load=0", thread_num, load_en); end
        tick();
        saw_save |= save_en;
        vec++; if (load_en !== 1'b1 || thread_num !== 4'd3 || cpu_en !== 1'b0) begin errs++; $display("FAIL first_load got load=%b num=%0d cpu=%b want 1/3/0", load_en, thread_num, cpu_en); end
        tick();
        saw_save |= save_en;
        vec++; if (cpu_en !== 1'b1 || load_en !== 1'b0) begin errs++; $display("FAIL first_run got cpu=%b load=%b want 1/0", cpu_en, load_en); end
        vec++; if (saw_save !== 1'b0) begin errs++; $display("FAIL first_no_save got save seen=%b want 0", saw_save); end
    endtask

    task automatic test_round_robin;
        bit ok, sw, sv_seen;
        logic [3:0] sv, ld;
        int gap;
        logic [3:0] exp_sv [4] = '{4'd2, 4'd5, 4'd9, 4'd2};
        logic [3:0] exp_ld [4] = '{4'd5, 4'd9, 4'd2, 4'd5};
        do_reset();
        pulse_set(4'd2);
        pulse_set(4'd5);
        pulse_set(4'd9);
        wait_load(ok, sw);
        vec++; if (!ok || thread_num !== 4'd2) begin errs++; $display("FAIL rr_first got ok=%b num=%0d want 1/2", ok, thread_num); end
        tick();
        vec++; if (ready_mask !== 16'h0224) begin errs++; $display("FAIL rr_mask got %h want 0224", ready_mask); end
        for (int k = 0; k < 4; k++) begin
            do_switch(1'b1, 1'b0, 4'd0, sv_seen, sv, ld, gap, ok);
            vec++; if (!sv_seen || sv !== exp_sv[k]) begin errs++; $display("FAIL rr_save%0d got seen=%b num=%0d want 1/%0d", k, sv_seen, sv, exp_sv[k]); end
            vec++; if (!ok || ld !== exp_ld[k] || thread_num !== exp_ld[k]) begin errs++; $display("FAIL rr_load%0d got ok=%b ld=%0d want 1/%0d", k, ok, ld, exp_ld[k]); end
        end
    endtask

    task automatic test_single_keep;
        bit ok, sw, sv_seen;
        logic [3:0] sv, ld;
        int gap;
        do_reset();
        pulse_set(4'd7);
        wait_load(ok, sw);
        tick();
        do_switch(1'b1, 1'b0, 4'd0, sv_seen, sv, ld, gap, ok);
        vec++; if (!sv_seen || sv !== 4'd7) begin errs++; $display("FAIL keep_save got seen=%b num=%0d want 1/7", sv_seen, sv); end
        vec++; if (!ok || ld !== 4'd7) begin errs++; $display("FAIL keep_load got ok=%b ld=%0d want 1/7", ok, ld); end
        vec++; if (gap !== 4) begin errs++; $display("FAIL keep_gap got %0d want 4", gap); end
    endtask

    task automatic test_single_drop;
        bit ok, sw, bad;
        do_reset();
        pulse_set(4'd7);
        wait_load(ok, sw);
        tick();
        switch_req = 1'b1;
        switch_keep = 1'b0;
        tick();
        switch_req = 1'b0;
        vec++; if (save_en !== 1'b1 || thread_num !== 4'd7) begin errs++; $display("FAIL drop_save got save=%b num=%0d want 1/7", save_en, thread_num); end
        vec++; if (ready_mask !== 16'h0) begin errs++; $display("FAIL drop_mask got %h want 0000", ready_mask); end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cpu_en || load_en || save_en) bad = 1'b1;
        end
        vec++; if (bad !== 1'b0) begin errs++; $display("FAIL drop_idle got activity=%b want 0", bad); end
        pulse_set(4'd1);
        wait_load(ok, sw);
        vec++; if (!ok || thread_num !== 4'd1) begin errs++; $display("FAIL drop_reload got ok=%b num=%0d want 1/1", ok, thread_num); end
    endtask

    task automatic test_set_wins;
        bit ok, sw, sv_seen;
        logic [3:0] sv, ld;
        int gap;
        do_reset();
        pulse_set(4'd4);
        wait_load(ok, sw);
        tick();
        do_switch(1'b0, 1'b1, 4'd4, sv_seen, sv, ld, gap, ok);
        vec++; if (ready_mask !== 16'h0010) begin errs++; $display("FAIL setwin_mask got %h want 0010", ready_mask); end
        vec++; if (!ok || ld !== 4'd4 || gap !== 4) begin errs++; $display("FAIL setwin_reload got ok=%b ld=%0d gap=%0d want 1/4/4", ok, ld, gap); end
    endtask

    task automatic test_reset_mid;
        bit ok, sw, bad;
        do_reset();
        pulse_set(4'd3);
        wait_load(ok, sw);
        reset = 1'b1;
        tick();
        vec++; if (thread_num !== 4'd15 || load_en || save_en || cpu_en || ready_mask !== 16'h0) begin errs++; $display("FAIL rst_load got num=%0d l=%b s=%b c=%b m=%h want 15/0/0/0/0000", thread_num, load_en, save_en, cpu_en, ready_mask); end
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (load_en || save_en || cpu_en) bad = 1'b1;
        end
        vec++; if (bad !== 1'b0) begin errs++; $display("FAIL rst_load_quiet got activity=%b want 0", bad); end
        pulse_set(4'd6);
        wait_load(ok, sw);
        tick();
        switch_req = 1'b1;
        switch_keep = 1'b1;
        tick();
        switch_req = 1'b0;
        vec++; if (save_en !== 1'b1) begin errs++; $display("FAIL rst_presave got save=%b want 1", save_en); end
        reset = 1'b1;
        tick();
        vec++; if (thread_num !== 4'd15 || load_en || save_en || cpu_en || ready_mask !== 16'h0) begin errs++; $display("FAIL rst_save got num=%0d l=%b s=%b c=%b m=%h want 15/0/0/0/0000", thread_num, load_en, save_en, cpu_en, ready_mask); end
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (load_en || save_en || cpu_en) bad = 1'b1;
        end
        vec++; if (bad !== 1'b0) begin errs++; $display("FAIL rst_save_quiet got activity=%b want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_round_robin();
        test_single_keep();
        test_single_drop();
        test_set_wins();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
